// File: rtl/prio_encoder_rr.sv
// Registered N-way priority encoder with fixed-priority or round-robin winner
// selection. The winner index and its one-hot vector are presented behind a
// valid/ready handshake.
module prio_encoder_rr #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot
);

  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [N-1:0]     out_onehot_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  logic             load;
  logic             handshake;
  logic [N-1:0]     req_eff;
  logic [N-1:0]     ge_mask;
  logic [N-1:0]     masked_req;
  logic [N-1:0]     sel_vec;
  logic [N-1:0]     win_onehot;
  logic [IDX_W-1:0] win_idx;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign load      = !out_valid_q || out_ready;
  assign handshake = out_valid_q && out_ready;
  assign req_eff   = en ? req : '0;

  // The winner loaded on a handshake edge must already see the advanced
  // pointer, otherwise round-robin would repeat each grant twice.
  always_comb begin
    ptr_d = ptr_q;
    if (handshake && mode) begin
      if (out_idx_q == IDX_W'(N - 1)) ptr_d = '0;
      else                            ptr_d = out_idx_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign ge_mask[gi] = (IDX_W'(gi) >= ptr_d);
    end
  endgenerate

  assign masked_req = req_eff & ge_mask;

  always_comb begin
    sel_vec = req_eff;
    if (mode && (|masked_req)) sel_vec = masked_req;
  end

  // Isolating the lowest set bit yields the one-hot directly.
  assign win_onehot = sel_vec & (~sel_vec + N'(1));
  assign win_idx    = lowest_set(sel_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      ptr_q        <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        out_valid_q  <= |sel_vec;
        out_idx_q    <= win_idx;
        out_onehot_q <= win_onehot;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: an N=8 and an N=5 instance, directed stimulus,
// expected winners queued per grant and checked by handshake monitors.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, en8, mode8, rdy8, valid8;
  logic [7:0] req8, onehot8;
  logic [2:0] idx8;

  logic       rst5, en5, mode5, rdy5, valid5;
  logic [4:0] req5, onehot5;
  logic [2:0] idx5;

  int n_checks = 0;
  int n_fail   = 0;
  int q8[$];
  int q5[$];

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .req(req8),
    .out_valid(valid8), .out_ready(rdy8), .out_idx(idx8), .out_onehot(onehot8)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst(rst5), .en(en5), .mode(mode5), .req(req5),
    .out_valid(valid5), .out_ready(rdy5), .out_idx(idx5), .out_onehot(onehot5)
  );

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d at %0t", name, act, $time);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] r, input logic e, input logic m, input logic rd);
    req8 = r; en8 = e; mode8 = m; rdy8 = rd;
  endtask

  task automatic drive5(input logic [4:0] r, input logic e, input logic m, input logic rd);
    req5 = r; en5 = e; mode5 = m; rdy5 = rd;
  endtask

  // Monitors: every accepted grant must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst8 && valid8 && rdy8) begin
      if (q8.size() == 0) begin
        check("n8 unexpected grant", int'(idx8), -1);
      end else begin
        int e;
        e = q8.pop_front();
        check("n8 grant idx", int'(idx8), e);
        check("n8 grant onehot", int'(onehot8), 1 << e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst5 && valid5 && rdy5) begin
      if (q5.size() == 0) begin
        check("n5 unexpected grant", int'(idx5), -1);
      end else begin
        int e;
        e = q5.pop_front();
        check("n5 grant idx", int'(idx5), e);
        check("n5 grant onehot", int'(onehot5), 1 << e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst8 = 1'b1; rst5 = 1'b1;
    drive8(8'h00, 1'b0, 1'b0, 1'b0);
    drive5(5'h00, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    check("reset valid", int'(valid8), 0);
    check("reset idx", int'(idx8), 0);
    check("reset onehot", int'(onehot8), 0);
    rst8 = 1'b0; rst5 = 1'b0;
    cyc();

    // Fixed priority, then a three-cycle stall with req changed underneath.
    drive8(8'b0110_1000, 1'b1, 1'b0, 1'b1);
    q8.push_back(3);
    cyc();
    check("fixed valid", int'(valid8), 1);
    check("fixed idx", int'(idx8), 3);
    check("fixed onehot", int'(onehot8), 8'h08);
    drive8(8'h01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall hold idx", int'(idx8), 3);
      check("stall hold valid", int'(valid8), 1);
    end
    drive8(8'h01, 1'b1, 1'b0, 1'b1);
    q8.push_back(0);
    cyc();
    check("after stall idx", int'(idx8), 0);
    drive8(8'h00, 1'b1, 1'b0, 1'b1);
    cyc();
    check("drained valid", int'(valid8), 0);

    // Asynchronous reset pulse between edges.
    #1 rst8 = 1'b1;
    #1 check("async reset valid", int'(valid8), 0);
    #1 rst8 = 1'b0;
    cyc();

    // Round-robin over all-ones: 0..7 then wrap 0,1.
    drive8(8'hFF, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) q8.push_back(i % 8);
    repeat (10) cyc();
    drive8(8'h00, 1'b1, 1'b1, 1'b1);
    cyc();

    // Pointer at 2: grant 2..5, then req 0101 wraps to 0, then 2.
    drive8(8'hFF, 1'b1, 1'b1, 1'b1);
    q8.push_back(2); q8.push_back(3); q8.push_back(4); q8.push_back(5);
    repeat (4) cyc();
    drive8(8'b0000_0101, 1'b1, 1'b1, 1'b1);
    q8.push_back(0); q8.push_back(2);
    repeat (2) cyc();
    drive8(8'h00, 1'b1, 1'b1, 1'b1);
    cyc();
    check("rr drained valid", int'(valid8), 0);

    // Disabled encoder and empty request both present nothing.
    drive8(8'hFF, 1'b0, 1'b1, 1'b1);
    cyc();
    check("en0 valid", int'(valid8), 0);
    check("en0 idx", int'(idx8), 0);
    check("en0 onehot", int'(onehot8), 0);
    drive8(8'h00, 1'b1, 1'b0, 1'b1);
    cyc();
    check("req0 valid", int'(valid8), 0);
    check("req0 onehot", int'(onehot8), 0);

    // Single set bits win regardless of pointer (ptr is 3 here).
    drive8(8'h10, 1'b1, 1'b1, 1'b1);
    q8.push_back(4);
    cyc();
    drive8(8'h00, 1'b1, 1'b1, 1'b1);
    cyc();
    drive8(8'h08, 1'b1, 1'b1, 1'b1);
    q8.push_back(3);
    cyc();
    drive8(8'h00, 1'b1, 1'b1, 1'b1);
    cyc();
    drive8(8'h80, 1'b1, 1'b0, 1'b1);
    q8.push_back(7);
    cyc();
    drive8(8'h00, 1'b1, 1'b0, 1'b1);
    cyc();

    // N=5 round-robin wraps at 5; reset during a stall discards the winner.
    drive5(5'b11111, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) q5.push_back(i % 5);
    repeat (7) cyc();
    drive5(5'b00000, 1'b1, 1'b0, 1'b0);
    cyc();
    check("n5 stall idx", int'(idx5), 1);
    check("n5 stall valid", int'(valid5), 1);
    #1 rst5 = 1'b1;
    #1;
    check("n5 mid-stall reset valid", int'(valid5), 0);
    check("n5 mid-stall reset idx", int'(idx5), 0);
    check("n5 mid-stall reset onehot", int'(onehot5), 0);
    cyc();
    rst5 = 1'b0;
    drive5(5'b11111, 1'b1, 1'b1, 1'b1);
    q5.push_back(0);
    cyc();
    check("n5 first after reset idx", int'(idx5), 0);
    drive5(5'b00000, 1'b1, 1'b1, 1'b1);
    cyc();

    repeat (2) cyc();
    check("n8 queue drained", q8.size(), 0);
    check("n5 queue drained", q5.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
